// File: rtl/mem_master.sv
// Load/store bridge between a core request port and a single-ported word memory.
// Define MEM_MASTER_SUBWORD_EN for byte/halfword support; otherwise sub-word requests are rejected.
module mem_master #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_type,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_input_data,
  output logic        mem_write,
  output logic        mem_read,
  output logic        mem_type,
  input  logic [31:0] mem_output_data
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
`ifdef MEM_MASTER_SUBWORD_EN
    RMW_READ,
    RMW_WRITE,
`endif
    RESP
  } state_t;

  state_t state, next_state;

  logic [29:0] idx_q;
  logic        type_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_data_q;
  logic        resp_error_q;
  logic        req_error;
  logic [31:0] load_word;

`ifdef MEM_MASTER_SUBWORD_EN
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        unsigned_q;
  logic [31:0] rmw_word_q;
  logic [31:0] store_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
`else
  logic        unused_req_bits;
  assign unused_req_bits = req_unsigned;
`endif

  // Legality is judged on the live request so IDLE can route it on the accepting edge.
  always_comb begin
    req_error = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
`ifdef MEM_MASTER_SUBWORD_EN
    case (req_size)
      2'd1:    if (req_addr[0]) req_error = 1'b1;
      2'd2:    if (req_addr[1:0] != 2'b00) req_error = 1'b1;
      2'd3:    req_error = 1'b1;
      default: ;
    endcase
`else
    if (req_size != 2'd2 || req_addr[1:0] != 2'b00) req_error = 1'b1;
`endif
  end

`ifdef MEM_MASTER_SUBWORD_EN
  always_comb begin
    byte_sel = mem_output_data[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_output_data[31:16] : mem_output_data[15:0];
    case (size_q)
      2'd0:    load_word = unsigned_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    load_word = unsigned_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_word = mem_output_data;
    endcase
  end

  // Merge the store lane into the word captured during RMW_READ.
  always_comb begin
    store_word = rmw_word_q;
    case (size_q)
      2'd0: store_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      2'd1: begin
        if (lane_q[1]) store_word[31:16] = wdata_q[15:0];
        else           store_word[15:0]  = wdata_q[15:0];
      end
      default: store_word = wdata_q;
    endcase
  end
`else
  assign load_word = mem_output_data;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Strobes are decoded from state alone so an asynchronous reset drops them at once.
  always_comb begin
    next_state     = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'b0;
    mem_input_data = 32'b0;
    mem_type       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_error)          next_state = RESP;
          else if (!req_write)    next_state = READ;
`ifdef MEM_MASTER_SUBWORD_EN
          else if (req_size != 2'd2) next_state = RMW_READ;
`endif
          else                    next_state = WRITE;
        end
      end
      READ: begin
        mem_read    = 1'b1;
        mem_address = {2'b00, idx_q};
        mem_type    = type_q;
        next_state  = RESP;
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_address    = {2'b00, idx_q};
        mem_type       = type_q;
        mem_input_data = wdata_q;
        next_state     = RESP;
      end
`ifdef MEM_MASTER_SUBWORD_EN
      RMW_READ: begin
        mem_read    = 1'b1;
        mem_address = {2'b00, idx_q};
        mem_type    = type_q;
        next_state  = RMW_WRITE;
      end
      RMW_WRITE: begin
        mem_write      = 1'b1;
        mem_address    = {2'b00, idx_q};
        mem_type       = type_q;
        mem_input_data = store_word;
        next_state     = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      type_q       <= 1'b0;
      wdata_q      <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
`ifdef MEM_MASTER_SUBWORD_EN
      size_q       <= '0;
      lane_q       <= '0;
      unsigned_q   <= 1'b0;
      rmw_word_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx_q        <= req_addr[31:2];
            type_q       <= req_type;
            wdata_q      <= req_wdata;
            resp_data_q  <= '0;
            resp_error_q <= req_error;
`ifdef MEM_MASTER_SUBWORD_EN
            size_q       <= req_size;
            lane_q       <= req_addr[1:0];
            unsigned_q   <= req_unsigned;
`endif
          end
        end
        READ: resp_data_q <= load_word;
`ifdef MEM_MASTER_SUBWORD_EN
        RMW_READ: rmw_word_q <= mem_output_data;
`endif
        RESP: begin
          if (resp_ready) begin
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a two-array behavioural memory.
// Expected values follow the build: sub-word cases expect errors unless MEM_MASTER_SUBWORD_EN is defined.
module tb_mem_master;

  localparam logic MEM_ROM = 1'b0;
  localparam logic MEM_RAM = 1'b1;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_type, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_data;
  logic [31:0] mem_address, mem_input_data;
  logic        mem_write, mem_read, mem_type;
  logic [31:0] mem_output_data = 32'b0;

  logic [31:0] ram_mem [64];
  logic [31:0] rom_mem [64];

  int vector_count = 0;
  int fail_count = 0;
  int read_count = 0;
  int write_count = 0;
  int last_latency, last_reads, last_writes;
  logic [31:0] last_data;
  logic        last_error;

  mem_master #(.MEM_WORDS(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_error(resp_error),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_type(mem_type),
    .mem_output_data(mem_output_data)
  );

  always #5 clock = ~clock;

  // Read data appears at the negedge of a read cycle; writes commit mid-cycle.
  always @(negedge clock) begin
    if (mem_read) begin
      read_count++;
      mem_output_data = (mem_type == MEM_RAM) ? ram_mem[mem_address[5:0]] : rom_mem[mem_address[5:0]];
    end
    if (mem_write) begin
      write_count++;
      if (mem_type == MEM_RAM) ram_mem[mem_address[5:0]] = mem_input_data;
      else                     rom_mem[mem_address[5:0]] = mem_input_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic typ, input logic [31:0] addr,
                               input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    int r0, w0;
    r0 = read_count;
    w0 = write_count;
    req_valid = 1'b1; req_write = wr; req_type = typ; req_addr = addr;
    req_size = size; req_unsigned = uns; req_wdata = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0;
    last_latency = 1;
    while (!resp_valid && last_latency < 20) begin
      @(posedge clock); #1;
      last_latency++;
    end
    last_data  = resp_data;
    last_error = resp_error;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    last_reads  = read_count - r0;
    last_writes = write_count - w0;
  endtask

  task automatic checkTxn(input string tag, input int lat, input logic [31:0] data,
                          input logic err, input int rd, input int wr);
    checkOutput({tag, ".latency"}, 32'(last_latency), 32'(lat));
    checkOutput({tag, ".data"},    last_data, data);
    checkOutput({tag, ".error"},   32'(last_error), 32'(err));
    checkOutput({tag, ".reads"},   32'(last_reads), 32'(rd));
    checkOutput({tag, ".writes"},  32'(last_writes), 32'(wr));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_type = 1'b0; req_addr = 32'b0;
    req_size = 2'b0; req_unsigned = 1'b0; req_wdata = 32'b0; resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 32'h0;
      rom_mem[i] = 32'hA000_0000 | 32'(i);
    end
    ram_mem[5]  = 32'hDEADBEEF;
    ram_mem[3]  = 32'h33333333;
    rom_mem[3]  = 32'hCAFEF00D;
    ram_mem[7]  = 32'h0BADF00D;
    ram_mem[63] = 32'h600D0063;

    #12;
    checkOutput("rst.req_ready",  32'(req_ready), 32'd1);
    checkOutput("rst.resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst.resp_error", 32'(resp_error), 32'd0);
    checkOutput("rst.resp_data",  resp_data, 32'h0);
    checkOutput("rst.mem_read",   32'(mem_read), 32'd0);
    checkOutput("rst.mem_write",  32'(mem_write), 32'd0);
    checkOutput("rst.mem_address", mem_address, 32'h0);
    checkOutput("rst.mem_input",  mem_input_data, 32'h0);
    checkOutput("rst.mem_type",   32'(mem_type), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    applyStimulus(1'b0, MEM_RAM, 32'h14, SZ_W, 1'b0, 32'h0);
    checkTxn("ld_word", 2, 32'hDEADBEEF, 1'b0, 1, 0);
    applyStimulus(1'b1, MEM_RAM, 32'h20, SZ_W, 1'b0, 32'h12345678);
    checkTxn("st_word", 2, 32'h0, 1'b0, 0, 1);
    checkOutput("st_word.mem", ram_mem[8], 32'h12345678);
    applyStimulus(1'b0, MEM_ROM, 32'h0C, SZ_W, 1'b0, 32'h0);
    checkTxn("ld_rom", 2, 32'hCAFEF00D, 1'b0, 1, 0);
    applyStimulus(1'b0, MEM_RAM, 32'hFC, SZ_W, 1'b0, 32'h0);
    checkTxn("ld_last_idx", 2, 32'h600D0063, 1'b0, 1, 0);

    ram_mem[2] = 32'h80FF0000;
`ifdef MEM_MASTER_SUBWORD_EN
    applyStimulus(1'b0, MEM_RAM, 32'h0B, SZ_B, 1'b0, 32'h0);
    checkTxn("ld_sbyte", 2, 32'hFFFFFF80, 1'b0, 1, 0);
    applyStimulus(1'b0, MEM_RAM, 32'h0B, SZ_B, 1'b1, 32'h0);
    checkTxn("ld_ubyte", 2, 32'h00000080, 1'b0, 1, 0);
    applyStimulus(1'b0, MEM_RAM, 32'h0A, SZ_H, 1'b0, 32'h0);
    checkTxn("ld_shalf", 2, 32'hFFFF80FF, 1'b0, 1, 0);
    applyStimulus(1'b0, MEM_RAM, 32'h0A, SZ_H, 1'b1, 32'h0);
    checkTxn("ld_uhalf", 2, 32'h000080FF, 1'b0, 1, 0);
    ram_mem[2] = 32'h11223344;
    applyStimulus(1'b1, MEM_RAM, 32'h09, SZ_B, 1'b0, 32'h000000AA);
    checkTxn("st_byte", 3, 32'h0, 1'b0, 1, 1);
    checkOutput("st_byte.mem", ram_mem[2], 32'h1122AA44);
    applyStimulus(1'b1, MEM_RAM, 32'h0A, SZ_H, 1'b0, 32'hFFFFBEEF);
    checkTxn("st_half", 3, 32'h0, 1'b0, 1, 1);
    checkOutput("st_half.mem", ram_mem[2], 32'hBEEFAA44);
`else
    applyStimulus(1'b0, MEM_RAM, 32'h0B, SZ_B, 1'b0, 32'h0);
    checkTxn("ld_sbyte", 1, 32'h0, 1'b1, 0, 0);
    applyStimulus(1'b0, MEM_RAM, 32'h0A, SZ_H, 1'b1, 32'h0);
    checkTxn("ld_uhalf", 1, 32'h0, 1'b1, 0, 0);
    ram_mem[2] = 32'h11223344;
    applyStimulus(1'b1, MEM_RAM, 32'h09, SZ_B, 1'b0, 32'h000000AA);
    checkTxn("st_byte", 1, 32'h0, 1'b1, 0, 0);
    checkOutput("st_byte.mem", ram_mem[2], 32'h11223344);
`endif

    applyStimulus(1'b0, MEM_RAM, 32'h03, SZ_H, 1'b0, 32'h0);
    checkTxn("err_half_align", 1, 32'h0, 1'b1, 0, 0);
    applyStimulus(1'b0, MEM_RAM, 32'h100, SZ_W, 1'b0, 32'h0);
    checkTxn("err_range", 1, 32'h0, 1'b1, 0, 0);
    applyStimulus(1'b0, MEM_RAM, 32'h16, SZ_W, 1'b0, 32'h0);
    checkTxn("err_word_align", 1, 32'h0, 1'b1, 0, 0);
    applyStimulus(1'b1, MEM_RAM, 32'h10, 2'd3, 1'b0, 32'h55555555);
    checkTxn("err_size3", 1, 32'h0, 1'b1, 0, 0);
    checkOutput("err_size3.mem", ram_mem[4], 32'h0);

    // Hold the response, then release it while a new request is already waiting.
    req_valid = 1'b1; req_write = 1'b0; req_type = MEM_RAM; req_addr = 32'h1C;
    req_size = SZ_W; req_unsigned = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp.resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("bp.resp_data",  resp_data, 32'h0BADF00D);
      checkOutput("bp.req_ready",  32'(req_ready), 32'd0);
      @(posedge clock); #1;
    end
    req_valid = 1'b1; req_addr = 32'h14;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checkOutput("bp.released",   32'(resp_valid), 32'd0);
    checkOutput("bp.no_accept",  32'(req_ready), 32'd1);
    checkOutput("bp.no_read",    32'(mem_read), 32'd0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    checkOutput("bp.next_read",  32'(mem_read), 32'd1);
    @(posedge clock); #1;
    checkOutput("bp.next_valid", 32'(resp_valid), 32'd1);
    checkOutput("bp.next_data",  resp_data, 32'hDEADBEEF);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;

    // Asynchronous reset in the middle of a memory access.
`ifdef MEM_MASTER_SUBWORD_EN
    ram_mem[2] = 32'h11223344;
    req_valid = 1'b1; req_write = 1'b1; req_type = MEM_RAM; req_addr = 32'h09;
    req_size = SZ_B; req_wdata = 32'h000000AA;
`else
    req_valid = 1'b1; req_write = 1'b0; req_type = MEM_RAM; req_addr = 32'h14;
    req_size = SZ_W;
`endif
    @(posedge clock); #1;
    req_valid = 1'b0;
    checkOutput("midrst.read_before", 32'(mem_read), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst.read_dropped", 32'(mem_read), 32'd0);
    checkOutput("midrst.addr_dropped", mem_address, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("midrst.no_resp",  32'(resp_valid), 32'd0);
      checkOutput("midrst.no_write", 32'(mem_write), 32'd0);
      @(posedge clock); #1;
    end
    checkOutput("midrst.req_ready", 32'(req_ready), 32'd1);
`ifdef MEM_MASTER_SUBWORD_EN
    checkOutput("midrst.mem", ram_mem[2], 32'h11223344);
`else
    checkOutput("midrst.mem", ram_mem[5], 32'hDEADBEEF);
`endif

    applyStimulus(1'b0, MEM_RAM, 32'h14, SZ_W, 1'b0, 32'h0);
    checkTxn("recover", 2, 32'hDEADBEEF, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter: MEM_WORDS, 64, words per memory array; word index >= MEM_WORDS is out of range.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_type  input  1  target array, encoded with the existing MEM_ROM / MEM_RAM definitions.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
REQ-010 req_unsigned  input  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  core consumes the response.
REQ-014 resp_data  output  32  load result; 0 for stores and errors.
REQ-015 resp_error  output  1  request rejected without memory access.
REQ-016 mem_address  output  32  word index (req_addr >> 2) to the memory.
REQ-017 mem_input_data  output  32  write data to the memory.
REQ-018 mem_write / mem_read  output  1 each  memory strobes.
REQ-019 mem_type  output  1  array select to the memory.
REQ-020 mem_output_data  input  32  memory read data, valid after the negedge of a mem_read cycle.

Function
REQ-021 States SHALL be IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP.
REQ-022 IDLE: req_ready=1; only IDLE asserts req_ready; on req_valid at posedge, latch all req_* fields.
REQ-023 From IDLE: error -> RESP; load -> READ; word store -> WRITE; sub-word store -> RMW_READ.
REQ-024 Error SHALL be: req_size==3, halfword with addr[0]=1, word with addr[1:0]!=0, or word index >= MEM_WORDS.
REQ-025 READ / RMW_READ: exactly one cycle, mem_read=1, mem_address and mem_type from latched request; mem_output_data captured at the closing posedge.
REQ-026 WRITE / RMW_WRITE: exactly one cycle, mem_write=1, mem_input_data = store word; then RESP.
REQ-027 RMW merge: byte lane addr[1:0] (byte) or half lane addr[1] (halfword) of the captured word replaced by low bits of req_wdata; other lanes unchanged.
REQ-028 Load result: selected lane extracted, extended per req_unsigned; word loads pass through.
REQ-029 RESP: resp_valid=1, resp_data/resp_error stable until posedge with resp_ready=1, then IDLE.
REQ-030 Latency accept-to-resp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-031 Outside READ/RMW_READ mem_read=0; outside WRITE/RMW_WRITE mem_write=0; mem_read and mem_write never both 1.
REQ-032 No new request accepted while resp_valid=1, even if resp_ready=1 that cycle (one idle cycle between responses).

Reset
REQ-033 On reset: state IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_data=0, mem_read=0, mem_write=0, mem_address=0, mem_input_data=0, mem_type=0.
REQ-034 Reset mid-access SHALL drop strobes immediately; an in-flight request is discarded with no response.

Configuration
REQ-035 Macro MEM_MASTER_SUBWORD_EN defined: byte/halfword handling per REQ-023..028.
REQ-036 Macro undefined: RMW states and lane logic absent; req_size 0/1 SHALL be flagged as error; word path unchanged.

Verification
REQ-037 Word load RAM idx 5 holding 32'hDEADBEEF, addr 0x14 -> resp_valid 2 cycles after accept, resp_data 32'hDEADBEEF, one mem_read pulse.
REQ-038 Byte store 8'hAA to addr 0x09 on RAM word 32'h11223344 -> mem_read cycle then mem_write cycle, stored word 32'h1122AA44.
REQ-039 Signed byte load addr 0x0B, word 32'h80FF0000 -> resp_data 32'hFFFFFF80; with req_unsigned=1 -> 32'h00000080.
REQ-040 Halfword load addr 0x03 -> resp_error=1 after 1 cycle, no strobes; word load addr 0x100 with MEM_WORDS=64 -> resp_error=1.
REQ-041 resp_ready held 0 for 5 cycles -> resp_valid/resp_data stable, req_ready=0 throughout.
REQ-042 reset asserted during RMW_READ -> mem_read falls without waiting for clock, no resp_valid, memory word unchanged.
